branch_predict_ctrl: RTL and testbench

- Fetch-side branch prediction controller for the pipelined RISC-V CPU, 1-bit BHT variant.
- Holds a direct-mapped BTB with one 1-bit history bit per entry, and picks the next fetch PC.
- Produces the BranchFlagsF/BranchIndexF bundle that the IF-ID segment register carries down the pipe.
- When the branch resolves in EX, it detects mispredicts, redirects the PC, issues ID/EX flushes, updates the table and keeps statistics counters.

---
 rtl/bp_pkg.sv | 21 ++
 rtl/bp_btb_table.sv | 59 +++++
 rtl/branch_predict_ctrl.sv | 126 ++++++++++++
 tb/tb_branch_predict_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-side branch predictor and the segment registers
// that carry its flags/index bundle from IF down to EX.
package bp_pkg;

  localparam int unsigned BP_INDEX_W = 3;
  localparam int unsigned BP_ENTRIES = 1 << BP_INDEX_W;
  localparam int unsigned BP_TAG_W   = 32 - BP_INDEX_W - 2;

  localparam int unsigned BP_FLAG_HIT  = 1;
  localparam int unsigned BP_FLAG_PRED = 0;

  typedef struct packed {
    logic [1:0]            flags;
    logic [BP_INDEX_W-1:0] index;
  } bp_bundle_t;

  function automatic logic [BP_INDEX_W-1:0] bp_pc_index(input logic [31:0] pc);
    return pc[BP_INDEX_W+1:2];
  endfunction

endpackage

// File: rtl/bp_btb_table.sv
// Direct-mapped BTB storage: async lookup read, async EX-side target read, one sync write.
// Only the valid bits are reset; tag/target/history are don't-care until allocated.
module bp_btb_table #(
  parameter int unsigned IndexW = 3,
  parameter int unsigned TagW   = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IndexW-1:0] lu_idx_i,
  output logic              lu_valid_o,
  output logic [TagW-1:0]   lu_tag_o,
  output logic [31:0]       lu_target_o,
  output logic              lu_hist_o,
  input  logic [IndexW-1:0] ex_idx_i,
  output logic [31:0]       ex_target_o,
  input  logic              wr_en_i,
  input  logic [IndexW-1:0] wr_idx_i,
  input  logic              wr_alloc_i,
  input  logic [TagW-1:0]   wr_tag_i,
  input  logic              wr_target_en_i,
  input  logic [31:0]       wr_target_i,
  input  logic              wr_hist_i
);

  localparam int unsigned Entries = 1 << IndexW;

  logic [Entries-1:0] valid_q;
  logic [Entries-1:0] hist_q;
  logic [TagW-1:0]    tag_q    [Entries];
  logic [31:0]        target_q [Entries];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en_i && wr_alloc_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      hist_q[wr_idx_i] <= wr_hist_i;
      if (wr_alloc_i) begin
        tag_q[wr_idx_i] <= wr_tag_i;
      end
      if (wr_target_en_i) begin
        target_q[wr_idx_i] <= wr_target_i;
      end
    end
  end

  // Reads see pre-write contents; no same-cycle bypass.
  assign lu_valid_o  = valid_q[lu_idx_i];
  assign lu_tag_o    = tag_q[lu_idx_i];
  assign lu_target_o = target_q[lu_idx_i];
  assign lu_hist_o   = hist_q[lu_idx_i];
  assign ex_target_o = target_q[ex_idx_i];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Fetch-side 1-bit BHT branch predictor: BTB lookup and next-PC pick in IF,
// mispredict detection, redirect/flush, table update and statistics in EX.
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_W = BP_INDEX_W,
  parameter int unsigned ENTRIES = BP_ENTRIES,
  parameter int unsigned TAG_W   = BP_TAG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        PCF,
  input  logic               StallF,
  output logic [1:0]         BranchFlagsF,
  output logic [INDEX_W-1:0] BranchIndexF,
  output logic [31:0]        PredNPCF,
  input  logic               BranchE,
  input  logic               BranchTakenE,
  input  logic [31:0]        BranchTargetE,
  input  logic [31:0]        PCE,
  input  logic [1:0]         BranchFlagsE,
  input  logic [INDEX_W-1:0] BranchIndexE,
  input  logic               StallE,
  output logic               MispredE,
  output logic [31:0]        RedirectPCE,
  output logic               FlushD,
  output logic               FlushE,
  output logic [31:0]        BranchCnt,
  output logic [31:0]        MispredCnt
);

  logic              lu_valid;
  logic [TAG_W-1:0]  lu_tag;
  logic [31:0]       lu_target;
  logic              lu_hist;
  logic [31:0]       ex_target;
  logic              hit_f;
  logic              pred_taken_f;
  bp_bundle_t        bundle_f;

  logic              resolve_e;
  logic              was_hit_e;
  logic              pred_taken_e;
  logic              stale_e;
  logic              mispred_e;
  logic              wr_en;
  logic              wr_alloc;

  logic [31:0]       branch_cnt_q;
  logic [31:0]       mispred_cnt_q;

  // StallF only freezes the fetch PC upstream; lookup has no side effects to gate.
  logic              unused_stall_f;
  assign unused_stall_f = StallF;

  bp_btb_table #(
    .IndexW (INDEX_W),
    .TagW   (TAG_W)
  ) u_btb (
    .clk            (clk),
    .rst_n          (rst_n),
    .lu_idx_i       (PCF[INDEX_W+1:2]),
    .lu_valid_o     (lu_valid),
    .lu_tag_o       (lu_tag),
    .lu_target_o    (lu_target),
    .lu_hist_o      (lu_hist),
    .ex_idx_i       (BranchIndexE),
    .ex_target_o    (ex_target),
    .wr_en_i        (wr_en),
    .wr_idx_i       (BranchIndexE),
    .wr_alloc_i     (wr_alloc),
    .wr_tag_i       (PCE[31:INDEX_W+2]),
    .wr_target_en_i (BranchTakenE),
    .wr_target_i    (BranchTargetE),
    .wr_hist_i      (BranchTakenE)
  );

  // Lookup
  always_comb begin
    hit_f          = lu_valid && (lu_tag == PCF[31:INDEX_W+2]);
    pred_taken_f   = hit_f && lu_hist;
    bundle_f.flags = '0;
    bundle_f.flags[BP_FLAG_HIT]  = hit_f;
    bundle_f.flags[BP_FLAG_PRED] = pred_taken_f;
    bundle_f.index = bp_pc_index(PCF);
    PredNPCF       = pred_taken_f ? lu_target : PCF + 32'd4;
  end

  assign BranchFlagsF = bundle_f.flags;
  assign BranchIndexF = bundle_f.index;

  // Resolve
  always_comb begin
    resolve_e    = BranchE && !StallE;
    was_hit_e    = BranchFlagsE[BP_FLAG_HIT];
    pred_taken_e = BranchFlagsE[BP_FLAG_PRED];
    // Predicted and actually taken, but the stored target has gone stale.
    stale_e      = pred_taken_e && BranchTakenE && (ex_target != BranchTargetE);
    mispred_e    = resolve_e && ((pred_taken_e != BranchTakenE) || stale_e);
    RedirectPCE  = 32'd0;
    if (mispred_e) begin
      RedirectPCE = BranchTakenE ? BranchTargetE : PCE + 32'd4;
    end
    // A miss that falls through is never allocated.
    wr_en    = resolve_e && (was_hit_e || BranchTakenE);
    wr_alloc = !was_hit_e && BranchTakenE;
  end

  assign MispredE = mispred_e;
  assign FlushD   = mispred_e;
  assign FlushE   = mispred_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (resolve_e) begin
      branch_cnt_q  <= branch_cnt_q + 32'd1;
      mispred_cnt_q <= mispred_cnt_q + {31'd0, mispred_e};
    end
  end

  assign BranchCnt  = branch_cnt_q;
  assign MispredCnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: expected values are queued as stimulus
// is driven and popped against DUT outputs mid-cycle.
module tb_branch_predict_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] PCF;
  logic        StallF;
  logic [1:0]  BranchFlagsF;
  logic [2:0]  BranchIndexF;
  logic [31:0] PredNPCF;
  logic        BranchE;
  logic        BranchTakenE;
  logic [31:0] BranchTargetE;
  logic [31:0] PCE;
  logic [1:0]  BranchFlagsE;
  logic [2:0]  BranchIndexE;
  logic        StallE;
  logic        MispredE;
  logic [31:0] RedirectPCE;
  logic        FlushD;
  logic        FlushE;
  logic [31:0] BranchCnt;
  logic [31:0] MispredCnt;

  branch_predict_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCF           (PCF),
    .StallF        (StallF),
    .BranchFlagsF  (BranchFlagsF),
    .BranchIndexF  (BranchIndexF),
    .PredNPCF      (PredNPCF),
    .BranchE       (BranchE),
    .BranchTakenE  (BranchTakenE),
    .BranchTargetE (BranchTargetE),
    .PCE           (PCE),
    .BranchFlagsE  (BranchFlagsE),
    .BranchIndexE  (BranchIndexE),
    .StallE        (StallE),
    .MispredE      (MispredE),
    .RedirectPCE   (RedirectPCE),
    .FlushD        (FlushD),
    .FlushE        (FlushE),
    .BranchCnt     (BranchCnt),
    .MispredCnt    (MispredCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {SelFlags, SelIdx, SelNpc, SelMis, SelRedir, SelFlushD, SelFlushE,
                    SelBcnt, SelMcnt} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned exp_bcnt = 0;
  int unsigned exp_mcnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sel_e sel);
    case (sel)
      SelFlags:  return {30'd0, BranchFlagsF};
      SelIdx:    return {29'd0, BranchIndexF};
      SelNpc:    return PredNPCF;
      SelMis:    return {31'd0, MispredE};
      SelRedir:  return RedirectPCE;
      SelFlushD: return {31'd0, FlushD};
      SelFlushE: return {31'd0, FlushE};
      SelBcnt:   return BranchCnt;
      default:   return MispredCnt;
    endcase
  endfunction

  task automatic push(input string tag, input sel_e sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  // Fetch-only cycle: lookup plus counters against the running model.
  task automatic look(input string tag, input logic [31:0] pcf, input logic [1:0] flags,
                      input logic [31:0] npc);
    logic [31:0] pc_v;
    @(negedge clk);
    BranchE = 1'b0;
    StallE  = 1'b0;
    PCF     = pcf;
    pc_v    = pcf;
    #1;
    push({tag, "_flags"}, SelFlags, {30'd0, flags});
    push({tag, "_idx"}, SelIdx, {29'd0, pc_v[4:2]});
    push({tag, "_npc"}, SelNpc, npc);
    push({tag, "_mis"}, SelMis, 32'd0);
    push({tag, "_bcnt"}, SelBcnt, exp_bcnt);
    push({tag, "_mcnt"}, SelMcnt, exp_mcnt);
    drain();
  endtask

  task automatic resolve(input string tag, input logic [31:0] pce, input logic taken,
                         input logic [31:0] tgt, input logic [1:0] flags_e,
                         input logic stall, input logic exp_mis,
                         input logic [31:0] exp_redir);
    logic [31:0] pc_v;
    @(negedge clk);
    pc_v          = pce;
    BranchE       = 1'b1;
    PCE           = pce;
    BranchTakenE  = taken;
    BranchTargetE = tgt;
    BranchFlagsE  = flags_e;
    BranchIndexE  = pc_v[4:2];
    StallE        = stall;
    #1;
    push({tag, "_mis"}, SelMis, {31'd0, exp_mis});
    push({tag, "_redir"}, SelRedir, exp_redir);
    push({tag, "_flushd"}, SelFlushD, {31'd0, exp_mis});
    push({tag, "_flushe"}, SelFlushE, {31'd0, exp_mis});
    drain();
    if (!stall) begin
      exp_bcnt++;
      if (exp_mis) exp_mcnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0; PCF = 32'h10; StallF = 1'b0; BranchE = 1'b0; BranchTakenE = 1'b0;
    BranchTargetE = '0; PCE = '0; BranchFlagsE = '0; BranchIndexE = '0; StallE = 1'b0;
    #3;
    push("rst_flags", SelFlags, 32'd0);
    push("rst_idx", SelIdx, 32'd4);
    push("rst_npc", SelNpc, 32'h14);
    push("rst_mis", SelMis, 32'd0);
    push("rst_redir", SelRedir, 32'd0);
    push("rst_bcnt", SelBcnt, 32'd0);
    push("rst_mcnt", SelMcnt, 32'd0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;

    // Cold taken: lookup in the same cycle still misses (no bypass).
    resolve("cold", 32'h10, 1'b1, 32'h40, 2'b00, 1'b0, 1'b1, 32'h40);
    check_eq("cold_nobypass", {30'd0, BranchFlagsF}, 32'd0);
    look("trained", 32'h10, 2'b11, 32'h40);
    resolve("nt", 32'h10, 1'b0, 32'h40, 2'b11, 1'b0, 1'b1, 32'h14);
    look("hist_clr", 32'h10, 2'b10, 32'h14);
    resolve("retrain", 32'h10, 1'b1, 32'h40, 2'b10, 1'b0, 1'b1, 32'h40);
    look("retrained", 32'h10, 2'b11, 32'h40);
    resolve("stale_stall", 32'h10, 1'b1, 32'h44, 2'b11, 1'b1, 1'b0, 32'd0);
    look("after_stall", 32'h10, 2'b11, 32'h40);
    resolve("stale", 32'h10, 1'b1, 32'h44, 2'b11, 1'b0, 1'b1, 32'h44);
    look("stale_upd", 32'h10, 2'b11, 32'h44);
    resolve("correct", 32'h10, 1'b1, 32'h44, 2'b11, 1'b0, 1'b0, 32'd0);
    resolve("alias", 32'h30, 1'b1, 32'h80, 2'b00, 1'b0, 1'b1, 32'h80);
    look("evicted", 32'h10, 2'b00, 32'h14);
    look("alias_hit", 32'h30, 2'b11, 32'h80);
    resolve("miss_nt", 32'h104, 1'b0, 32'h300, 2'b00, 1'b0, 1'b0, 32'd0);
    look("no_alloc", 32'h104, 2'b00, 32'h108);
    look("wrap", 32'hFFFF_FFFC, 2'b00, 32'h0000_0000);

    // Bubble: outcome inputs active but BranchE low.
    @(negedge clk);
    BranchE = 1'b0; BranchTakenE = 1'b1; BranchFlagsE = 2'b00; BranchTargetE = 32'h500;
    #1;
    check_eq("bubble_mis", {31'd0, MispredE}, 32'd0);
    look("bubble_cnt", 32'h30, 2'b11, 32'h80);

    // Fresh counter run: 10 resolved, 3 mispredicts.
    @(negedge clk);
    rst_n = 1'b0;
    exp_bcnt = 0;
    exp_mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      resolve("cnt_nt", 32'h200, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'd0);
    end
    resolve("cnt_t0", 32'h204, 1'b1, 32'h600, 2'b00, 1'b0, 1'b1, 32'h600);
    resolve("cnt_t1", 32'h208, 1'b1, 32'h604, 2'b00, 1'b0, 1'b1, 32'h604);
    resolve("cnt_t2", 32'h20C, 1'b1, 32'h608, 2'b00, 1'b0, 1'b1, 32'h608);
    look("cnt", 32'h204, 2'b11, 32'h600);
    check_eq("cnt_b10", BranchCnt, 32'd10);
    check_eq("cnt_m3", MispredCnt, 32'd3);

    // Asynchronous reset mid-cycle, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_bcnt", BranchCnt, 32'd0);
    check_eq("arst_mcnt", MispredCnt, 32'd0);
    check_eq("arst_flags", {30'd0, BranchFlagsF}, 32'd0);
    check_eq("arst_npc", PredNPCF, 32'h208);
    PCF = 32'h30;
    #1;
    check_eq("arst_flags2", {30'd0, BranchFlagsF}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
